// File: rtl/fetch_stage.sv
// fetch_stage: RISC-V instruction fetch. Holds the fetch PC, issues word
// requests under a credit limit of DEPTH (outstanding + buffered), pairs
// in-order responses with a PC tag queue, buffers {instr, pc} in a DEPTH-entry
// queue and hands them to decode over valid/ready. Redirects flush both queues
// and drop whatever responses are still in flight (FLUSH state).
// Optional build macro FETCH_BYPASS_EN: a response that arrives while the
// queue is empty and nothing is being dropped goes straight to decode in the
// same cycle.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);
  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] DEPTH_X = (CW+1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_pc;
  logic [CW-1:0]   r_outst, r_drop, w_outst_nxt;
  logic [31:0]     r_iq_instr [DEPTH];
  logic [31:0]     r_iq_pc    [DEPTH];
  logic [AW-1:0]   r_iq_rd, r_iq_wr;
  logic [CW-1:0]   r_iq_cnt;
  logic [31:0]     r_tq_pc    [DEPTH];
  logic [AW-1:0]   r_tq_rd, r_tq_wr;

  logic [CW:0]     w_inflight;
  logic            w_credit, w_req_fire, w_rsp_fire, w_dropping, w_rsp_keep;
  logic            w_iq_empty, w_iq_push, w_iq_pop, w_byp;
  logic            w_unused;

  // Low PC bits never reach memory; fetch is word aligned.
  assign w_unused = ^redirect_pc[1:0];

  assign w_inflight     = {1'b0, r_outst} + {1'b0, r_iq_cnt};
  assign w_credit       = w_inflight < DEPTH_X;
  assign imem_req_valid = !rst & !redirect_valid & w_credit;
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  // A response with nothing outstanding is stray (e.g. issued before reset).
  assign w_rsp_fire  = imem_rsp_valid & (r_outst != '0);
  assign w_dropping  = (r_state == FLUSH);
  assign w_rsp_keep  = w_rsp_fire & !w_dropping;
  assign w_outst_nxt = r_outst + CW'(w_req_fire) - CW'(w_rsp_fire);

  assign w_iq_empty = (r_iq_cnt == '0);
`ifdef FETCH_BYPASS_EN
  assign w_byp = w_iq_empty & w_rsp_keep;
`else
  assign w_byp = 1'b0;
`endif
  // A bypassed response that decode takes this cycle never enters the queue.
  assign w_iq_push = w_rsp_keep & !redirect_valid & !(w_byp & id_ready);
  assign w_iq_pop  = id_ready & !w_iq_empty;

  // Decode view: queue head, or the live response when bypassing.
  always_comb begin
    id_valid = 1'b0;
    id_instr = NOP;
    id_pc    = '0;
    if (!w_iq_empty) begin
      id_valid = 1'b1;
      id_instr = r_iq_instr[r_iq_rd];
      id_pc    = r_iq_pc[r_iq_rd];
    end
`ifdef FETCH_BYPASS_EN
    else if (w_byp) begin
      id_valid = 1'b1;
      id_instr = imem_rsp_data;
      id_pc    = r_tq_pc[r_tq_rd];
    end
`endif
  end

  // FLUSH while stale responses are still owed; a redirect always re-decides.
  always_comb begin
    w_state_nxt = r_state;
    if (redirect_valid)
      w_state_nxt = (w_outst_nxt != '0) ? FLUSH : RUN;
    else if (r_state == FLUSH && w_rsp_fire && r_drop == CW'(1))
      w_state_nxt = RUN;
  end

  // Control state: PC, credit counters, queue pointers, FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_pc     <= {RESET_PC[31:2], 2'b00};
      r_outst  <= '0;
      r_drop   <= '0;
      r_iq_rd  <= '0;
      r_iq_wr  <= '0;
      r_iq_cnt <= '0;
      r_tq_rd  <= '0;
      r_tq_wr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_outst <= w_outst_nxt;
      if (redirect_valid) begin
        r_pc     <= {redirect_pc[31:2], 2'b00};
        r_drop   <= w_outst_nxt;
        r_iq_rd  <= '0;
        r_iq_wr  <= '0;
        r_iq_cnt <= '0;
        r_tq_rd  <= '0;
        r_tq_wr  <= '0;
      end else begin
        if (w_req_fire) begin
          r_pc    <= r_pc + 32'd4;
          r_tq_wr <= r_tq_wr + AW'(1);
        end
        if (w_rsp_fire && w_dropping) r_drop  <= r_drop - CW'(1);
        if (w_rsp_keep)               r_tq_rd <= r_tq_rd + AW'(1);
        if (w_iq_push)                r_iq_wr <= r_iq_wr + AW'(1);
        if (w_iq_pop)                 r_iq_rd <= r_iq_rd + AW'(1);
        r_iq_cnt <= r_iq_cnt + CW'(w_iq_push) - CW'(w_iq_pop);
      end
    end
  end

  // Queue payload storage; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (w_req_fire) r_tq_pc[r_tq_wr] <= r_pc;
    if (w_iq_push) begin
      r_iq_instr[r_iq_wr] <= imem_rsp_data;
      r_iq_pc[r_iq_wr]    <= r_tq_pc[r_tq_rd];
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model with configurable latency and
// a stream checker that expects decode to see consecutive PCs from the last
// reset/redirect target with instr = mem(pc), plus directed corner cases.
module tb_fetch_stage;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP    = 1'b1;
  localparam int MIN_HS = 27;
`else
  localparam bit BYP    = 1'b0;
  localparam int MIN_HS = 18;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        id_valid, id_ready = 1'b0;
  logic [31:0] id_instr, id_pc;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc)
  );

  int n_tests = 0, n_fail = 0;

  typedef struct { logic [31:0] addr; int unsigned due; } pend_t;
  pend_t pend[$];
  int unsigned cyc = 0;

  int k_rdy = 100, k_idr = 100, k_lat_lo = 1, k_lat_hi = 1, k_redir_pct = 0;
  bit k_redir = 0, k_redir_on_rsp = 0, k_rst = 0, k_rand_rpc = 0;
  logic [31:0] k_rpc = '0;

  bit          o_reqv, o_fire, o_idv, o_rsp, o_hs, o_redir;
  logic [31:0] o_addr, o_pc, o_instr;
  logic [31:0] exp_pc = RPC;
  int          n_hs = 0;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, observe after settling, update models.
  task automatic step();
    @(negedge clk);
    cyc++;
    rst = k_rst;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memw(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    imem_req_ready = ($urandom_range(99) < k_rdy);
    id_ready       = ($urandom_range(99) < k_idr);
    redirect_valid = k_redir | (k_redir_on_rsp & imem_rsp_valid) |
                     ($urandom_range(99) < k_redir_pct);
    redirect_pc    = k_rand_rpc ? $urandom : k_rpc;
    #1;
    o_reqv  = imem_req_valid;
    o_fire  = imem_req_valid & imem_req_ready;
    o_addr  = imem_req_addr;
    o_idv   = id_valid;
    o_pc    = id_pc;
    o_instr = id_instr;
    o_rsp   = imem_rsp_valid;
    o_redir = redirect_valid;
    o_hs    = id_valid & id_ready & !redirect_valid & !rst;
    if (!id_valid) begin
      chk("empty_instr", id_instr, NOP);
      chk("empty_pc", id_pc, 32'h0);
    end
    if (redirect_valid | rst) chk("req_blocked", imem_req_valid, 1'b0);
    chk("credit_limit", pend.size() <= DEPTH, 1'b1);
    if (o_hs) begin
      chk("stream_pc", id_pc, exp_pc);
      chk("stream_instr", id_instr, memw(exp_pc));
      exp_pc += 32'd4;
      n_hs++;
    end
    if (rst) exp_pc = RPC;
    else if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
    if (o_fire)
      pend.push_back('{imem_req_addr, cyc + $urandom_range(k_lat_hi, k_lat_lo)});
    if (imem_rsp_valid) void'(pend.pop_front());
  endtask

  // Let every in-flight response return and decode empty the queue.
  task automatic drain();
    int sv = k_rdy;
    int g = 0;
    k_rdy = 0;
    k_idr = 100;
    while (pend.size() != 0 && g < 40) begin step(); g++; end
    chk("drain_done", pend.size(), 0);
    repeat (4) step();
    k_rdy = sv;
  endtask

  typedef struct { logic [31:0] rpc, exp_addr, exp_next; } vec_t;
  vec_t tbl [4];

  initial begin
    int g, n0;
    tbl[0] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204};
    tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
    tbl[2] = '{32'h0000_0101, 32'h0000_0100, 32'h0000_0104};
    tbl[3] = '{32'h8000_0002, 32'h8000_0000, 32'h8000_0004};

    // reset state
    k_rst = 1; step(); step(); k_rst = 0;
    k_rdy = 0; step();
    chk("rst_req_valid", o_reqv, 1'b1);
    chk("rst_req_addr", o_addr, RPC);
    chk("rst_id_valid", o_idv, 1'b0);
    chk("rst_id_instr", o_instr, NOP);
    chk("rst_id_pc", o_pc, 32'h0);

    // 1-cycle memory streaming and response-to-decode latency
    k_rdy = 100; k_idr = 100; k_lat_lo = 1; k_lat_hi = 1;
    step();
    chk("first_fire", o_fire, 1'b1);
    chk("first_addr", o_addr, RPC);
    step();
    chk("first_rsp", o_rsp, 1'b1);
    chk("bypass_latency", o_idv, BYP);
    step();
    chk("lat1_id_valid", o_idv, 1'b1);
    chk("lat1_id_pc", o_pc, BYP ? RPC + 32'd4 : RPC);
    n0 = n_hs;
    repeat (30) step();
    chk("throughput", (n_hs - n0) >= MIN_HS, 1'b1);

    // decode stall: credit caps requests, nothing lost on release
    k_idr = 0;
    repeat (10) step();
    chk("stall_req_blocked", o_reqv, 1'b0);
    chk("stall_id_valid", o_idv, 1'b1);
    k_idr = 100; n0 = n_hs;
    repeat (10) step();
    chk("stall_release", (n_hs - n0) >= 5, 1'b1);

    // redirect alignment / wrap table
    k_lat_lo = 2; k_lat_hi = 2;
    for (int i = 0; i < 4; i++) begin
      k_redir = 1; k_rpc = tbl[i].rpc; step(); k_redir = 0;
      chk($sformatf("tbl%0d_redir_block", i), o_reqv, 1'b0);
      step();
      chk($sformatf("tbl%0d_addr", i), o_addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_id_valid", i), o_idv, 1'b0);
      g = 0;
      while (!o_fire && g < 20) begin step(); g++; end
      chk($sformatf("tbl%0d_fire", i), o_fire, 1'b1);
      chk($sformatf("tbl%0d_fire_addr", i), o_addr, tbl[i].exp_addr);
      step();
      chk($sformatf("tbl%0d_next_addr", i), o_addr, tbl[i].exp_next);
    end

    // redirect with two responses in flight (3-cycle memory)
    drain();
    k_lat_lo = 3; k_lat_hi = 3; k_rdy = 100;
    g = 0;
    while (pend.size() != 2 && g < 20) begin step(); g++; end
    chk("flush_setup", pend.size(), 2);
    k_redir = 1; k_rpc = 32'h0000_0100; step(); k_redir = 0;
    step();
    chk("flush_addr", o_addr, 32'h0000_0100);
    chk("flush_id_valid", o_idv, 1'b0);
    chk("flush_credit_block", o_reqv, 1'b0);
    g = 0;
    while (!o_hs && g < 30) begin step(); g++; end
    chk("flush_hs", o_hs, 1'b1);
    chk("flush_first_pc", o_pc, 32'h0000_0100);

    // redirect and response in the same cycle
    drain();
    k_lat_lo = 1; k_lat_hi = 1; k_rdy = 100;
    k_redir_on_rsp = 1; k_rpc = 32'h0000_0203;
    g = 0;
    do begin step(); g++; end while (!(o_redir & o_rsp) && g < 20);
    k_redir_on_rsp = 0;
    chk("rr_hit", o_redir & o_rsp, 1'b1);
    step();
    chk("rr_addr", o_addr, 32'h0000_0200);
    chk("rr_id_valid", o_idv, 1'b0);
    repeat (8) step();

    // reset mid-stream with one request outstanding
    drain();
    k_lat_lo = 3; k_lat_hi = 3; k_rdy = 100;
    step();
    chk("rst_mid_setup", pend.size(), 1);
    k_rdy = 0; k_rst = 1; step(); k_rst = 0;
    step();
    chk("rst_mid_addr", o_addr, RPC);
    chk("rst_mid_id_valid", o_idv, 1'b0);
    g = 0;
    while (pend.size() != 0 && g < 10) begin
      step(); g++;
      chk("stray_id_valid", o_idv, 1'b0);
    end
    step();
    chk("stray_ignored", o_idv, 1'b0);
    k_rdy = 100; n0 = n_hs;
    repeat (10) step();
    chk("rst_mid_resume", (n_hs - n0) >= 1, 1'b1);

    // randomized traffic with redirects
    drain();
    k_rdy = 70; k_idr = 70; k_lat_lo = 1; k_lat_hi = 4;
    k_redir_pct = 3; k_rand_rpc = 1; n0 = n_hs;
    repeat (3000) step();
    k_redir_pct = 0; k_rand_rpc = 0; k_idr = 100;
    drain();
    chk("random_progress", (n_hs - n0) > 100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
